// File: rtl/spi_master.sv
// spi_master: byte-wide SPI mode-0 master (CPOL=0, CPHA=0), drives sclk/cs_n/mosi, samples miso.
// Latency: start accept edge T0 -> done pulse at T0 + 17*CLK_DIV clk cycles.
// Backpressure: start is taken only while busy=0; a start seen while busy is dropped, never queued.
//
// Ports:
//   clk, rst        system clock (rising edge), asynchronous active-low reset
//   start, din      one-cycle transfer request and the byte to send (captured on accept)
//   busy, done      busy spans accept..done edge; done pulses one cycle as dout updates
//   dout            last received byte, held until the next done
//   sclk, cs_n      serial clock (idles low) and active-low chip select
//   mosi, miso      serial data out / in
//
// Build option: define SPI_MASTER_MSB_FIRST_EN to shift MSB first in both directions;
// undefined (default) shifts LSB first. Timing and handshakes are the same in both builds.

module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       miso,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] div_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    tx_sh;
  logic [7:0]    rx_sh;

  // Bit-order dependent datapath: the bit presented first, the TX register
  // after a shift, the bit that shift exposes on mosi, and the RX register
  // after absorbing the current miso sample.
  logic       first_bit;
  logic [7:0] tx_shifted;
  logic       next_bit;
  logic [7:0] rx_next;

  always_comb begin
    first_bit  = 1'b0;
    tx_shifted = 8'h00;
    next_bit   = 1'b0;
    rx_next    = 8'h00;
`ifdef SPI_MASTER_MSB_FIRST_EN
    first_bit  = din[7];
    tx_shifted = {tx_sh[6:0], 1'b0};
    next_bit   = tx_sh[6];
    rx_next    = {rx_sh[6:0], miso};
`else
    first_bit  = din[0];
    tx_shifted = {1'b0, tx_sh[7:1]};
    next_bit   = tx_sh[1];
    rx_next    = {miso, rx_sh[7:1]};
`endif
  end

  // Every non-idle state lasts exactly CLK_DIV cycles; tick marks its last one.
  logic tick;
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      bit_cnt <= 4'd0;
      tx_sh   <= 8'h00;
      rx_sh   <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      dout    <= 8'h00;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      // done is a single-cycle strobe; only the HOLD exit raises it.
      done <= 1'b0;

      case (state)
        S_IDLE: begin
          div_cnt <= '0;
          if (start) begin
            tx_sh   <= din;
            rx_sh   <= 8'h00;
            bit_cnt <= 4'd0;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            mosi    <= first_bit;
            state   <= S_SETUP;
          end
        end

        // First bit already sits on mosi; give the slave one half-period of
        // setup before the first rising edge.
        S_SETUP: begin
          if (tick) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
            state   <= S_HIGH;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        // Sample miso and drop sclk on the same edge; the falling edge is also
        // where mosi moves to the next bit.
        S_HIGH: begin
          if (tick) begin
            div_cnt <= '0;
            rx_sh   <= rx_next;
            sclk    <= 1'b0;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              state <= S_HOLD;
            end else begin
              tx_sh <= tx_shifted;
              mosi  <= next_bit;
              state <= S_LOW;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_LOW: begin
          if (tick) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
            state   <= S_HIGH;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        // Keep cs_n low one more half-period after the last falling edge so
        // the slave sees a clean hold time before deselect.
        S_HOLD: begin
          if (tick) begin
            div_cnt <= '0;
            cs_n    <= 1'b1;
            dout    <= rx_sh;
            done    <= 1'b1;
            busy    <= 1'b0;
            mosi    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: begin
          div_cnt <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized scoreboard bench for spi_master at CLK_DIV=2 and CLK_DIV=1.
// Latency: n/a (bench).
// Backpressure: n/a (bench).

module tb_spi_master;

`ifdef SPI_MASTER_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      start_w;
  logic [1:0][7:0] din_w;
  logic [1:0]      miso_w;
  logic [1:0]      busy_w;
  logic [1:0]      done_w;
  logic [1:0][7:0] dout_w;
  logic [1:0]      sclk_w;
  logic [1:0]      cs_w;
  logic [1:0]      mosi_w;

  spi_master #(.CLK_DIV(2)) u_div2 (
    .clk(clk), .rst(rst), .start(start_w[0]), .din(din_w[0]), .miso(miso_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .dout(dout_w[0]),
    .sclk(sclk_w[0]), .cs_n(cs_w[0]), .mosi(mosi_w[0])
  );

  spi_master #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .start(start_w[1]), .din(din_w[1]), .miso(miso_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .dout(dout_w[1]),
    .sclk(sclk_w[1]), .cs_n(cs_w[1]), .mosi(mosi_w[1])
  );

  function automatic int div(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Slave model. mode 0: loopback (miso=mosi); 1: constant level; 2: slave
  // byte sent in link bit order, advancing after each observed sclk fall.
  int         mode    [2];
  logic       cval    [2];
  logic [7:0] sbyte   [2];
  int         fall_cnt[2];
  logic [2:0] sidx    [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sidx[i]   = MSB ? 3'(7 - fall_cnt[i]) : 3'(fall_cnt[i]);
      miso_w[i] = (mode[i] == 0) ? mosi_w[i] :
                  (mode[i] == 1) ? cval[i]   : sbyte[i][sidx[i]];
    end
  end

  typedef struct {
    int         inst;
    logic [7:0] din;
    logic [7:0] exp;
    int         acc;
    int         gap;
  } xfer_t;

  xfer_t sb_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: observes both serial ports away from the active edge and checks
  // each done against the oldest scoreboard entry.
  int         rise_cnt [2];
  int         last_rise[2];
  int         cs_fall  [2];
  int         cs_rise  [2];
  int         gap_seen [2];
  logic [7:0] mosi_cap [2];
  logic       p_sclk   [2];
  logic       p_cs     [2];
  logic       p_done   [2];
  int         mpos;
  xfer_t      e;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        p_sclk[i] = 1'b0;
        p_cs[i]   = 1'b1;
        p_done[i] = 1'b0;
      end else begin
        if (!cs_w[i] && p_cs[i]) begin
          cs_fall[i]  = cyc;
          gap_seen[i] = cyc - cs_rise[i];
          rise_cnt[i] = 0;
          fall_cnt[i] = 0;
          mosi_cap[i] = 8'h00;
        end
        if (cs_w[i] && !p_cs[i]) cs_rise[i] = cyc;
        if (sclk_w[i] && !p_sclk[i]) begin
          if (rise_cnt[i] > 0) chk("sclk_period", cyc - last_rise[i], 2 * div(i));
          last_rise[i] = cyc;
          if (rise_cnt[i] < 8) begin
            mpos = MSB ? 7 - rise_cnt[i] : rise_cnt[i];
            mosi_cap[i][mpos] = mosi_w[i];
          end
          rise_cnt[i]++;
        end
        if (!sclk_w[i] && p_sclk[i]) fall_cnt[i]++;
        if (done_w[i]) begin
          chk("done_prev_cycle", p_done[i], 0);
          if (sb_q.size() == 0 || sb_q[0].inst != i) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: inst %0d got done with no pending transfer (cycle %0d)", i, cyc);
          end else begin
            e = sb_q.pop_front();
            chk("dout", dout_w[i], e.exp);
            chk("done_latency", cyc - e.acc, 17 * div(i));
            chk("sclk_rises", rise_cnt[i], 8);
            chk("mosi_byte", mosi_cap[i], e.din);
            chk("cs_low_cycles", cyc - cs_fall[i], 17 * div(i));
            chk("busy_at_done", busy_w[i], 0);
            chk("cs_at_done", cs_w[i], 1);
            if (e.gap > 0) chk("cs_high_gap", gap_seen[i], e.gap);
          end
        end
        p_sclk[i] = sclk_w[i];
        p_cs[i]   = cs_w[i];
        p_done[i] = done_w[i];
      end
    end
  end

  // Issue one transfer; when now=1 the caller is already on the negedge where
  // start must go high (back-to-back from the done cycle).
  task automatic issue(input int i, input logic [7:0] d, input int md, input logic cv,
                       input logic [7:0] sbv, input int gap, input bit now);
    xfer_t x;
    if (!now) @(negedge clk);
    mode[i]    = md;
    cval[i]    = cv;
    sbyte[i]   = sbv;
    start_w[i] = 1'b1;
    din_w[i]   = d;
    @(negedge clk);
    start_w[i] = 1'b0;
    din_w[i]   = 8'($urandom);
    x.inst = i;
    x.din  = d;
    x.exp  = (md == 0) ? d : (md == 1) ? {8{cv}} : sbv;
    x.acc  = cyc;
    x.gap  = gap;
    sb_q.push_back(x);
  endtask

  task automatic wait_done(input int i);
    int n = 0;
    while (sb_q.size() != 0 && n < 60 * div(i)) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: inst %0d got %0d pending expected 0", i, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic wait_done_edge(input int i);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 60 * div(i)) begin
      @(negedge clk);
      n++;
      seen = done_w[i];
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_edge_timeout: inst %0d got no done expected one", i);
    end
  endtask

  task automatic chk_idle(input int i, input string tag);
    chk({tag, "_cs_n"}, cs_w[i], 1);
    chk({tag, "_sclk"}, sclk_w[i], 0);
    chk({tag, "_mosi"}, mosi_w[i], 0);
    chk({tag, "_busy"}, busy_w[i], 0);
    chk({tag, "_done"}, done_w[i], 0);
    chk({tag, "_dout"}, dout_w[i], 0);
  endtask

  initial begin
    int n;
    int inst;
    int md;
    rst     = 1'b0;
    start_w = '0;
    din_w   = '0;
    for (int i = 0; i < 2; i++) begin
      mode[i]     = 0;
      cval[i]     = 1'b0;
      sbyte[i]    = 8'h00;
      fall_cnt[i] = 0;
      rise_cnt[i] = 0;
      cs_rise[i]  = 0;
    end
    repeat (3) @(negedge clk);
    chk_idle(0, "reset0");
    chk_idle(1, "reset1");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback 0xA5 at CLK_DIV=2.
    issue(0, 8'hA5, 0, 1'b0, 8'h00, 0, 1'b0);
    wait_done(0);

    // Bit order: only bit 0 of din high, miso held high.
    issue(0, 8'h01, 1, 1'b1, 8'h00, 0, 1'b0);
    wait_done(0);

    // start while busy is dropped; the original byte completes alone.
    issue(0, 8'h96, 2, 1'b0, 8'h3B, 0, 1'b0);
    repeat (10) @(negedge clk);
    start_w[0] = 1'b1;
    din_w[0]   = 8'h3C;
    @(negedge clk);
    start_w[0] = 1'b0;
    wait_done(0);
    repeat (40) @(negedge clk);

    // Back-to-back from the done cycle: cs_n high for exactly one clk.
    issue(0, 8'h11, 0, 1'b0, 8'h00, 0, 1'b0);
    wait_done_edge(0);
    issue(0, 8'h5A, 0, 1'b0, 8'h00, 1, 1'b1);
    wait_done(0);

    // Reset after the third sclk rising edge.
    issue(0, 8'hE7, 0, 1'b0, 8'h00, 0, 1'b0);
    n = 0;
    while (rise_cnt[0] < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rises_before_reset", (rise_cnt[0] >= 3), 1);
    #2 rst = 1'b0;
    #1 chk_idle(0, "mid_reset");
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    issue(0, 8'h3C, 2, 1'b0, 8'hD2, 0, 1'b0);
    wait_done(0);

    // CLK_DIV=1 loopback.
    issue(1, 8'hC3, 0, 1'b0, 8'h00, 0, 1'b0);
    wait_done(1);

    // Randomized transfers on both instances, some back-to-back.
    for (int k = 0; k < 40; k++) begin
      inst = $urandom_range(0, 1);
      md   = $urandom_range(0, 2);
      issue(inst, 8'($urandom), md, 1'($urandom), 8'($urandom), 0, 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        wait_done_edge(inst);
        md = $urandom_range(0, 2);
        issue(inst, 8'($urandom), md, 1'($urandom), 8'($urandom), 1, 1'b1);
      end
      wait_done(inst);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
